trng_sched: RTL and testbench

- Sequencer and output scheduler for the NLFSR-based TRNG datapath.
- Drives the datapath phase enables (load, init, run, NLFSR3 chip-enable).
- Collects warbler bits into words and delivers them over a valid/ready handshake.
- Forces a periodic reseed, and runs a repetition-count health test on the raw bit stream.

---
 rtl/trng_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_trng_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_sched.sv
// trng_sched: phase sequencer, word collector, reseed scheduler and
// repetition-count health test for the NLFSR-based TRNG datapath.
module trng_sched #(
  parameter int LOAD_CYCLES  = 80,
  parameter int INIT_CYCLES  = 160,
  parameter int WORD_W       = 32,
  parameter int RESEED_WORDS = 1024,
  parameter int RCT_LIMIT    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              warbler_i,
  output logic              load_en,
  output logic              init_en,
  output logic              run_en,
  output logic              nlfsr3_ce,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int CYC_MAX = (LOAD_CYCLES > INIT_CYCLES) ? LOAD_CYCLES : INIT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int XFER_W  = $clog2(RESEED_WORDS + 1);
  localparam int RUN_W   = $clog2(RCT_LIMIT + 1);

  localparam logic [CYC_W-1:0]  LOAD_LAST = CYC_W'(LOAD_CYCLES - 1);
  localparam logic [CYC_W-1:0]  INIT_LAST = CYC_W'(INIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(RESEED_WORDS - 1);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(RCT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_RUN,
    S_STALL,
    S_FAIL
  } state_t;

  state_t            r_state, w_next;
  logic [CYC_W-1:0]  r_cyc_cnt, w_cyc_next;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_next;
  logic [XFER_W-1:0] r_xfer_cnt, w_xfer_next;
  logic [RUN_W-1:0]  r_run_cnt, w_run_next;
  logic [WORD_W-1:0] r_shift, w_shift_next;
  logic [WORD_W-1:0] r_word, w_hold_src;
  logic              r_valid, w_hold_ld;
  logic              r_load_en, r_init_en, r_run_en, r_ce, r_busy, r_health_fail;

  logic              w_accept;
  logic              w_word_done;
  logic              w_xfer_last;
  logic              w_fail_entry;
  logic [WORD_W-1:0] w_shift_in;
  logic [RUN_W-1:0]  w_run_inc;

  assign w_accept    = r_valid & word_ready;
  assign w_word_done = (r_bit_cnt == BIT_LAST);
  assign w_xfer_last = (r_xfer_cnt == XFER_LAST);
  assign w_shift_in  = {warbler_i, r_shift[WORD_W-1:1]};
  // The MSB of the shift register is always the most recently collected bit,
  // so the run length carries across word boundaries and stalls.
  assign w_run_inc   = ((r_run_cnt != '0) && (warbler_i == r_shift[WORD_W-1]))
                       ? r_run_cnt + RUN_W'(1) : RUN_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_cyc_next   = r_cyc_cnt;
    w_bit_next   = r_bit_cnt;
    w_xfer_next  = r_xfer_cnt;
    w_run_next   = r_run_cnt;
    w_shift_next = r_shift;
    w_hold_ld    = 1'b0;
    w_hold_src   = r_shift;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (r_cyc_cnt == LOAD_LAST) begin
          w_next     = S_INIT;
          w_cyc_next = '0;
        end else begin
          w_cyc_next = r_cyc_cnt + CYC_W'(1);
        end
      end
      S_INIT: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (r_cyc_cnt == INIT_LAST) begin
          w_next     = S_RUN;
          w_cyc_next = '0;
        end else begin
          w_cyc_next = r_cyc_cnt + CYC_W'(1);
        end
      end
      S_RUN: begin
        w_shift_next = w_shift_in;
        w_run_next   = w_run_inc;
        w_bit_next   = w_word_done ? '0 : r_bit_cnt + BIT_W'(1);
        if (w_run_inc == RUN_LIMIT) begin
          w_next = S_FAIL;
        end else if (stop) begin
          w_next = S_IDLE;
        end else if (w_word_done) begin
          if (!r_valid || w_accept) begin
            w_hold_ld  = 1'b1;
            w_hold_src = w_shift_in;
            if (w_xfer_last) begin
              w_next      = S_LOAD;
              w_xfer_next = '0;
            end else begin
              w_xfer_next = r_xfer_cnt + XFER_W'(1);
            end
          end else begin
            w_next = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (w_accept) begin
          w_hold_ld = 1'b1;
          if (w_xfer_last) begin
            w_next      = S_LOAD;
            w_xfer_next = '0;
          end else begin
            w_next      = S_RUN;
            w_xfer_next = r_xfer_cnt + XFER_W'(1);
          end
        end
      end
      S_FAIL: begin
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Partial words never survive a seeding pass, an abort or a failure.
    if (w_next != r_state) begin
      if (w_next == S_LOAD) begin
        w_shift_next = '0;
        w_bit_next   = '0;
        w_run_next   = '0;
        w_cyc_next   = '0;
      end else if (w_next == S_IDLE || w_next == S_FAIL) begin
        w_shift_next = '0;
        w_bit_next   = '0;
      end
    end
  end

  assign w_fail_entry = (w_next == S_FAIL) && (r_state != S_FAIL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cyc_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_xfer_cnt <= '0;
      r_run_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_next;
      r_cyc_cnt  <= w_cyc_next;
      r_bit_cnt  <= w_bit_next;
      r_xfer_cnt <= w_xfer_next;
      r_run_cnt  <= w_run_next;
      r_shift    <= w_shift_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (w_fail_entry) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (w_hold_ld) begin
      r_valid <= 1'b1;
      r_word  <= w_hold_src;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Enables are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_en     <= 1'b0;
      r_init_en     <= 1'b0;
      r_run_en      <= 1'b0;
      r_ce          <= 1'b0;
      r_busy        <= 1'b0;
      r_health_fail <= 1'b0;
    end else begin
      r_load_en     <= (w_next == S_LOAD);
      r_init_en     <= (w_next == S_INIT);
      r_run_en      <= (w_next == S_RUN) || (w_next == S_STALL);
      r_ce          <= (w_next == S_RUN);
      r_busy        <= (w_next != S_IDLE);
      r_health_fail <= (w_next == S_FAIL);
    end
  end

  assign load_en     = r_load_en;
  assign init_en     = r_init_en;
  assign run_en      = r_run_en;
  assign nlfsr3_ce   = r_ce;
  assign busy        = r_busy;
  assign health_fail = r_health_fail;
  assign word_o      = r_word;
  assign word_valid  = r_valid;

endmodule

// File: tb/tb_trng_sched.sv
// Directed bench for trng_sched: sequencing, word assembly, back-pressure,
// reseed, health test and abort, with hand-computed expectations.
module tb_trng_sched;

  localparam int LOAD_C = 4;
  localparam int INIT_C = 6;
  localparam int W      = 8;
  localparam int RS     = 2;
  localparam int RCT    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         warbler_i;
  logic         word_ready;
  logic         load_en, init_en, run_en, nlfsr3_ce;
  logic [W-1:0] word_o;
  logic         word_valid;
  logic         busy, health_fail;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] seq;      // bits in time order, seq[7] first
    logic [7:0] exp_word;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[4];

  trng_sched #(
    .LOAD_CYCLES (LOAD_C),
    .INIT_CYCLES (INIT_C),
    .WORD_W      (W),
    .RESEED_WORDS(RS),
    .RCT_LIMIT   (RCT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .warbler_i  (warbler_i),
    .load_en    (load_en),
    .init_en    (init_en),
    .run_en     (run_en),
    .nlfsr3_ce  (nlfsr3_ce),
    .word_o     (word_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Order: load_en, init_en, run_en, nlfsr3_ce, busy, health_fail
  task automatic check_outs(input string name, input logic [5:0] exp);
    check(name, {load_en, init_en, run_en, nlfsr3_ce, busy, health_fail}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    warbler_i  = 1'b0;
    word_ready = 1'b1;
    step();
    step();
    check_outs("reset_outs", 6'b000000);
    check("reset_valid", word_valid, 1'b0);
    check("reset_word", word_o, 8'h00);
    rst = 1'b0;
    step();
  endtask

  task automatic start_seq();
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  // Starts on the first LOAD cycle, ends on the first RUN cycle.
  task automatic check_seed_pass(input string name, input logic chk_valid,
                                 input logic exp_valid, input logic [7:0] exp_word);
    for (int k = 0; k < LOAD_C + INIT_C; k++) begin
      check_outs(name, {(k < LOAD_C), (k >= LOAD_C), 4'b0010});
      if (chk_valid && k > 0) begin
        check({name, "_valid"}, word_valid, exp_valid);
        if (exp_valid) check({name, "_word"}, word_o, exp_word);
      end
      step();
    end
    check_outs({name, "_run"}, 6'b001110);
  endtask

  task automatic wait_ce();
    int n = 0;
    while (nlfsr3_ce !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (nlfsr3_ce !== 1'b1) check("ce_timeout", nlfsr3_ce, 1'b1);
  endtask

  task automatic feed_bit(input logic b);
    wait_ce();
    warbler_i = b;
    step();
  endtask

  task automatic feed_word(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) feed_bit(seq[i]);
  endtask

  initial begin
    vecs[0].seq = 8'b1010_1010; vecs[0].exp_word = 8'h55; vecs[0].exp_cyc = 19;
    vecs[1].seq = 8'b1100_1010; vecs[1].exp_word = 8'h53; vecs[1].exp_cyc = 27;
    vecs[2].seq = 8'b0111_0001; vecs[2].exp_word = 8'h8E; vecs[2].exp_cyc = 45;
    vecs[3].seq = 8'b1111_0000; vecs[3].exp_word = 8'h0F; vecs[3].exp_cyc = 53;

    // Reset state and start+stop collision in IDLE
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", busy, 1'b0);

    // Sequencing, word assembly and reseed with word_ready held high
    start_seq();
    check_seed_pass("seq", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      feed_word(vecs[i].seq);
      check("word_valid", word_valid, 1'b1);
      check("word_value", word_o, vecs[i].exp_word);
      check("word_cycle", cyc, vecs[i].exp_cyc);
      if (i % 2 == 1) check_seed_pass("reseed", 1'b1, 1'b0, 8'h00);
    end

    // Back-pressure: stall, reseed with a held word, stall released into RUN
    do_reset();
    word_ready = 1'b0;
    start_seq();
    check_seed_pass("bp_seq", 1'b0, 1'b0, 8'h00);
    feed_word(8'b1010_1010);
    check("bp_w0_valid", word_valid, 1'b1);
    check("bp_w0_word", word_o, 8'h55);
    feed_word(8'b1100_1010);
    check("bp_stall_cycle", cyc, 27);
    check_outs("bp_stall_outs", 6'b001010);
    check("bp_stall_word", word_o, 8'h55);
    step();
    check_outs("bp_stall_hold", 6'b001010);
    check("bp_stall_hold_word", word_o, 8'h55);
    check("bp_stall_hold_valid", word_valid, 1'b1);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("bp_xfer_word", word_o, 8'h53);
    check("bp_xfer_valid", word_valid, 1'b1);
    check_seed_pass("bp_reseed", 1'b1, 1'b1, 8'h53);
    feed_word(8'b0111_0001);
    check_outs("bp_stall2_outs", 6'b001010);
    check("bp_stall2_word", word_o, 8'h53);
    word_ready = 1'b1;
    step();
    check_outs("bp_resume_outs", 6'b001110);
    check("bp_resume_word", word_o, 8'h8E);
    check("bp_resume_valid", word_valid, 1'b1);
    step();
    check("bp_drained", word_valid, 1'b0);

    // Abort in RUN, then restart from a cleared bit and run-length count
    do_reset();
    start_seq();
    check_seed_pass("abort_seq", 1'b0, 1'b0, 8'h00);
    warbler_i = 1'b1;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("abort_idle", 6'b000000);
    check("abort_no_word", word_valid, 1'b0);
    start_seq();
    check_seed_pass("abort_restart", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) feed_bit(i < 5);
    check("abort_no_early_word", word_valid, 1'b0);
    check("abort_no_fail", health_fail, 1'b0);
    feed_bit(1'b0);
    check("abort_word_valid", word_valid, 1'b1);
    check("abort_word", word_o, 8'h1F);
    check("abort_word_cycle", cyc, 19);

    // Health: run crossing a word boundary kills a pending word
    do_reset();
    word_ready = 1'b0;
    start_seq();
    feed_word(8'b1010_1111);
    check("hc_word", word_o, 8'hF5);
    for (int i = 0; i < 3; i++) feed_bit(1'b1);
    check("hc_before", health_fail, 1'b0);
    check("hc_before_valid", word_valid, 1'b1);
    feed_bit(1'b1);
    check("hc_fail_cycle", cyc, 23);
    check_outs("hc_fail_outs", 6'b000011);
    check("hc_fail_valid", word_valid, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    step();
    check_outs("hc_sticky", 6'b000011);

    // Health: constant ones; FAIL beats word completion and stop
    do_reset();
    check("hf_cleared", health_fail, 1'b0);
    start_seq();
    for (int i = 0; i < 7; i++) feed_bit(1'b1);
    check("hf_before", health_fail, 1'b0);
    wait_ce();
    warbler_i = 1'b1;
    stop      = 1'b1;
    step();
    stop = 1'b0;
    check("hf_fail_cycle", cyc, 19);
    check_outs("hf_fail_outs", 6'b000011);
    check("hf_no_word", word_valid, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_outs("hf_start_ignored", 6'b000011);
    rst = 1'b1;
    #2;
    check_outs("hf_async_rst", 6'b000000);
    rst = 1'b0;
    step();
    check_outs("hf_after_rst", 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
